// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: default widths and the
// arbitration FSM state type.
package dmem_pkg;

  localparam int DATA_W       = 16;
  localparam int ADDR_W       = 4;
  localparam int STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_ram.sv
// Single-port DEPTH x DATA_W data RAM. Writes commit at the clock edge and
// read data comes out of a register one cycle after the address is presented.
module dmem_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // The array is deliberately left unreset so it maps onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the pipeline (P, priority) and the
// debug/loader port (D, starvation-protected, locked auto-incrementing bursts).
module dmem_arbiter #(
  parameter int DATA_W       = dmem_pkg::DATA_W,
  parameter int ADDR_W       = dmem_pkg::ADDR_W,
  parameter int STARVE_LIMIT = dmem_pkg::STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  // pipeline port
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  output logic              stall_out,
  // debug / loader port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] d_len,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done
);

  import dmem_pkg::*;

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t state_q, state_d;

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [ADDR_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic                we_q, we_d;

  logic                p_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0]   p_hold_q, d_hold_q;

  logic                starve_full;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_rdata;

  dmem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Next-state, grant and RAM port muxing. DONE shares the IDLE priority
  // rules for P but never starts a new D burst; it always returns to IDLE.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    len_d     = len_q;
    we_d      = we_q;
    p_gnt     = 1'b0;
    d_gnt     = 1'b0;
    d_done    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = p_addr;
    ram_wdata = p_wdata;

    starve_full = (starve_q == STARVE_W'(STARVE_LIMIT));

    case (state_q)
      BURST: begin
        if (d_req) begin
          d_gnt     = 1'b1;
          ram_we    = we_q;
          ram_addr  = addr_q + beat_q;
          ram_wdata = d_wdata;
          beat_d    = beat_q + ADDR_W'(1);
          if (beat_q == len_q) begin
            state_d = DONE;
          end
        end
      end

      default: begin
        d_done  = (state_q == DONE);
        state_d = IDLE;
        if (p_req && !(d_req && starve_full)) begin
          p_gnt     = 1'b1;
          ram_we    = p_we;
          ram_addr  = p_addr;
          ram_wdata = p_wdata;
          if (!d_req) begin
            starve_d = '0;
          end else if (!starve_full) begin
            starve_d = starve_q + STARVE_W'(1);
          end
        end else if (d_req && (state_q == IDLE)) begin
          // Beat 0 goes out straight from the request inputs.
          d_gnt     = 1'b1;
          ram_we    = d_we;
          ram_addr  = d_addr;
          ram_wdata = d_wdata;
          we_d      = d_we;
          addr_d    = d_addr;
          len_d     = d_len;
          beat_d    = ADDR_W'(1);
          starve_d  = '0;
          state_d   = (d_len == '0) ? DONE : BURST;
        end else if (!d_req) begin
          starve_d = '0;
        end
      end
    endcase
  end

  // State, counters and read-return steering. Hold registers keep rdata
  // stable between valid returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      beat_q     <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      we_q       <= 1'b0;
      p_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      p_hold_q   <= '0;
      d_hold_q   <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      beat_q     <= beat_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      we_q       <= we_d;
      p_rvalid_q <= p_gnt & ~p_we;
      d_rvalid_q <= d_gnt & ~ram_we;
      if (p_rvalid_q) begin
        p_hold_q <= ram_rdata;
      end
      if (d_rvalid_q) begin
        d_hold_q <= ram_rdata;
      end
    end
  end

  assign stall_out = p_req & ~p_gnt;
  assign p_rvalid  = p_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign p_rdata   = p_rvalid_q ? ram_rdata : p_hold_q;
  assign d_rdata   = d_rvalid_q ? ram_rdata : d_hold_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a queue/array reference model predicts
// grants per cycle and read data, which a separate monitor checks on return.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_req, p_we;
  logic [3:0]  p_addr;
  logic [15:0] p_wdata;
  logic        p_gnt, p_rvalid, stall_out;
  logic [15:0] p_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_addr, d_len;
  logic [15:0] d_wdata;
  logic        d_gnt, d_rvalid, d_done;
  logic [15:0] d_rdata;

  dmem_arbiter #(
    .DATA_W       (16),
    .ADDR_W       (4),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .p_req     (p_req),
    .p_we      (p_we),
    .p_addr    (p_addr),
    .p_wdata   (p_wdata),
    .p_gnt     (p_gnt),
    .p_rvalid  (p_rvalid),
    .p_rdata   (p_rdata),
    .stall_out (stall_out),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_len     (d_len),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_done    (d_done)
  );

  always #5 clk = ~clk;

  int vecCount = 0;
  int errCount = 0;

  // Reference model: memory image, remaining burst beat addresses, starvation
  // count and pending read-return expectations.
  logic [15:0] refMem [16];
  int          beatQ[$];
  bit          burstWe = 1'b0;
  int          starve = 0;
  bit          doneCycle = 1'b0;
  logic [15:0] pExpQ[$];
  logic [15:0] dExpQ[$];
  logic [15:0] pHold = 16'h0;
  logic [15:0] dHold = 16'h0;
  logic [15:0] pExp, dExp;
  bit          gotP, gotD;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict and check the combinational
  // grants mid-cycle, then advance the model at the edge.
  task automatic applyStimulus(input int r, input int pr, input int pw, input int pa,
                               input int pd, input int dr, input int dw, input int da,
                               input int dl, input int dd);
    bit inBurst, forceD, ePG, eDG, nextDone;
    int a;
    rst     = (r != 0);
    p_req   = (pr != 0);
    p_we    = (pw != 0);
    p_addr  = pa[3:0];
    p_wdata = pd[15:0];
    d_req   = (dr != 0);
    d_we    = (dw != 0);
    d_addr  = da[3:0];
    d_len   = dl[3:0];
    d_wdata = dd[15:0];

    inBurst = (beatQ.size() > 0);
    if (inBurst) begin
      ePG = 1'b0;
      eDG = (dr != 0);
    end else begin
      forceD = (dr != 0) && (starve == LIMIT);
      ePG    = (pr != 0) && !forceD;
      eDG    = !ePG && (dr != 0) && !doneCycle;
    end

    @(negedge clk);
    checkOutput("p_gnt", p_gnt, ePG);
    checkOutput("d_gnt", d_gnt, eDG);
    checkOutput("stall_out", stall_out, (pr != 0) && !ePG);
    checkOutput("d_done", d_done, doneCycle);

    @(posedge clk);
    gotP = ePG;
    gotD = eDG;
    nextDone = 1'b0;
    if (ePG) begin
      if (pw != 0) refMem[pa % 16] = pd[15:0];
      else if (r == 0) pExpQ.push_back(refMem[pa % 16]);
    end
    if (eDG) begin
      if (inBurst) begin
        a = beatQ.pop_front();
      end else begin
        a = da % 16;
        burstWe = (dw != 0);
        for (int i = 1; i <= dl; i++) beatQ.push_back((da + i) % 16);
      end
      if (burstWe) refMem[a] = dd[15:0];
      else if (r == 0) dExpQ.push_back(refMem[a]);
      nextDone = (beatQ.size() == 0);
    end
    if (!inBurst) begin
      if (eDG || dr == 0) starve = 0;
      else if (ePG && starve < LIMIT) starve++;
    end
    doneCycle = nextDone;
    if (r != 0) begin
      beatQ.delete();
      pExpQ.delete();
      dExpQ.delete();
      starve    = 0;
      doneCycle = 1'b0;
      pHold     = 16'h0;
      dHold     = 16'h0;
    end
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Read-return monitor: each expected return must appear exactly one cycle
  // after its grant; otherwise rdata must hold its previous value.
  always @(negedge clk) begin
    checkOutput("p_rvalid", p_rvalid, pExpQ.size() > 0);
    if (pExpQ.size() > 0) begin
      pExp = pExpQ.pop_front();
      checkOutput("p_rdata", p_rdata, pExp);
      pHold = pExp;
    end else begin
      checkOutput("p_rdata_hold", p_rdata, pHold);
    end
    checkOutput("d_rvalid", d_rvalid, dExpQ.size() > 0);
    if (dExpQ.size() > 0) begin
      dExp = dExpQ.pop_front();
      checkOutput("d_rdata", d_rdata, dExp);
      dHold = dExp;
    end else begin
      checkOutput("d_rdata_hold", d_rdata, dHold);
    end
  end

  bit pPend = 1'b0;
  int pW, pA, pD;
  int dPhase = 0;
  int dW, dA, dL, dr;

  initial begin
    for (int i = 0; i < 16; i++) refMem[i] = 16'h0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idleCycle();

    // Give the RAM a known image.
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 1, i, 16'hC000 + i * 16'h0111, 0, 0, 0, 0, 0);
    idleCycle();

    // P store then load of the same word.
    applyStimulus(0, 1, 1, 3, 16'h1234, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    idleCycle();

    // Both requesting: four P grants, D forced on the fifth, then DONE with P.
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, i, 0, 1, 1, 7, 0, 16'hBEEF);
    applyStimulus(0, 1, 0, 7, 0, 0, 0, 0, 0, 0);
    idleCycle();

    // Wrapping write burst 14,15,0,1; control inputs scrambled mid-burst.
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 14, 3, 16'h00A0);
    applyStimulus(0, 1, 0, 5, 0, 1, 0, 2, 9, 16'h00A1);
    applyStimulus(0, 1, 0, 5, 0, 1, 0, 6, 0, 16'h00A2);
    applyStimulus(0, 1, 0, 5, 0, 1, 1, 9, 1, 16'h00A3);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idleCycle();

    // Read burst with a bubble in the middle.
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 2, 2, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idleCycle();
    idleCycle();

    // Reset on the second beat of a len=5 write burst.
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 8, 5, 16'h5500);
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 8, 5, 16'h5501);
    idleCycle();
    idleCycle();
    for (int i = 8; i < 11; i++) applyStimulus(0, 1, 0, i, 0, 0, 0, 0, 0, 0);
    idleCycle();

    // Single-beat D write, P store lands in the DONE cycle.
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 4, 0, 16'h4444);
    applyStimulus(0, 1, 1, 5, 16'h5555, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 4, 0, 0, 0, 0, 0, 0);
    idleCycle();

    // Randomized traffic: P holds each request until granted; D holds until
    // its burst starts, bubbles at random inside, and rests for the DONE cycle.
    repeat (3000) begin
      if (!pPend && $urandom_range(0, 9) < 6) begin
        pPend = 1'b1;
        pW = $urandom_range(0, 1);
        pA = $urandom_range(0, 15);
        pD = $urandom_range(0, 65535);
      end
      if (dPhase == 0 && $urandom_range(0, 9) < 2) begin
        dPhase = 1;
        dW = $urandom_range(0, 1);
        dA = $urandom_range(0, 15);
        dL = $urandom_range(0, 15);
      end
      if (dPhase == 1) begin
        applyStimulus(0, pPend, pW, pA, pD, 1, dW, dA, dL, $urandom_range(0, 65535));
      end else begin
        dr = (dPhase == 2) ? ($urandom_range(0, 3) != 0) : 0;
        applyStimulus(0, pPend, pW, pA, pD, dr, $urandom_range(0, 1), $urandom_range(0, 15),
                      $urandom_range(0, 15), $urandom_range(0, 65535));
      end
      if (gotP) pPend = 1'b0;
      if (dPhase == 3) dPhase = 0;
      else if (gotD) dPhase = (beatQ.size() == 0) ? 3 : 2;
    end

    idleCycle();
    idleCycle();
    checkOutput("p_returns_drained", pExpQ.size(), 0);
    checkOutput("d_returns_drained", dExpQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
